frame_serialiser_p: RTL

Parametrised frame-to-stream serialiser for the trace path. It pulls fixed-width frames from the frame FIFO and emits them MS-first as OUT_W-bit beats over a valid/ready stream toward the UART/USB handler. It inserts status/sync frames at a programmable interval and decodes width and sync commands arriving on the serial receive path.

---
 rtl/frame_serialiser_pkg.sv | 29 ++
 rtl/fs_cmd_decoder.sv | 47 ++++
 rtl/frame_serialiser_p.sv | 124 ++++++++++++
 3 files changed

// File: rtl/frame_serialiser_pkg.sv
// Shared constants and types for the trace-path frame serialiser:
// sync frame framing words, receive-path command bytes and state encodings.
package frame_serialiser_pkg;

  localparam logic [7:0]  SYNC_HDR  = 8'hA6;
  localparam logic [31:0] SYNC_WORD = 32'hFFFFFF7F;

  localparam logic [7:0] CMD_WIDTH    = 8'h77;  // 'w'
  localparam logic [7:0] CMD_SYNC     = 8'h66;  // 'f'
  localparam logic [7:0] CMD_WIDTH_A0 = 8'hA0;
  localparam logic [7:0] CMD_WIDTH_A1 = 8'hA1;
  localparam logic [7:0] CMD_WIDTH_A2 = 8'hA2;
  localparam logic [7:0] CMD_WIDTH_A3 = 8'hA3;

  typedef enum logic {
    IDLE,
    SEND
  } fs_state_e;

  typedef enum logic {
    PRIMED_NONE,
    PRIMED_WIDTH
  } fs_primed_e;

  function automatic logic is_width_arg(input logic [7:0] b);
    return (b >= CMD_WIDTH_A0) && (b <= CMD_WIDTH_A3);
  endfunction

endpackage

// File: rtl/fs_cmd_decoder.sv
// Receive-path command decoder: 'w' + 0xA0..0xA3 sets the trace port width,
// 'f' requests an immediate sync frame.
module fs_cmd_decoder
  import frame_serialiser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rxed_event,
  input  logic [7:0] data_in_serial,
  output logic [1:0] width,
  output logic       force_sync
);

  fs_primed_e primed_q, primed_d;
  logic [1:0] width_q, width_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path infers a latch.
    primed_d = primed_q;
    width_d  = width_q;
    if (rxed_event) begin
      if (data_in_serial == CMD_WIDTH) begin
        primed_d = PRIMED_WIDTH;
      end else begin
        primed_d = PRIMED_NONE;
        if (primed_q == PRIMED_WIDTH && is_width_arg(data_in_serial)) begin
          width_d = data_in_serial[1:0];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= PRIMED_NONE;
      width_q  <= 2'h3;
    end else begin
      primed_q <= primed_d;
      width_q  <= width_d;
    end
  end

  assign width      = width_q;
  assign force_sync = rxed_event && (data_in_serial == CMD_SYNC);

endmodule

// File: rtl/frame_serialiser_p.sv
// Frame-to-stream serialiser: emits FIFO frames MS-first as OUT_W-bit beats and
// interleaves sync frames. Build with FRAME_SERIALISER_CMD_EN for the command decoder.
module frame_serialiser_p
  import frame_serialiser_pkg::*;
#(
  parameter int FRAME_W     = 128,
  parameter int OUT_W       = 8,
  parameter int BUFFLENLOG2 = 9,
  parameter int SYNC_LOG2   = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [1:0]             width,
  input  logic [FRAME_W-1:0]     frame,
  input  logic                   frame_ready,
  output logic                   frame_next,
  input  logic [BUFFLENLOG2-1:0] frames_cnt,
  output logic [OUT_W-1:0]       data_val,
  output logic                   data_valid,
  input  logic                   data_ready,
  input  logic                   rxed_event,
  input  logic [7:0]             data_in_serial,
  input  logic [7:0]             leds,
  input  logic [15:0]            lost_frames,
  input  logic [31:0]            total_frames
);

  localparam int BEATS   = FRAME_W / OUT_W;
  localparam int BEATS_W = $clog2(BEATS + 1);

  fs_state_e            state_q, state_d;
  logic [BEATS_W-1:0]   beats_q, beats_d;
  logic [SYNC_LOG2-1:0] sync_cnt_q, sync_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [FRAME_W-1:0]   sync_frame;
  logic                 load_sync;
  logic                 force_sync;

`ifdef FRAME_SERIALISER_CMD_EN
  fs_cmd_decoder u_cmd (
    .clk            (clk),
    .rst            (rst),
    .rxed_event     (rxed_event),
    .data_in_serial (data_in_serial),
    .width          (width),
    .force_sync     (force_sync)
  );
`else
  logic unused_cmd;
  assign width      = 2'h3;
  assign force_sync = 1'b0;
  assign unused_cmd = &{1'b0, rxed_event, data_in_serial};
`endif

  // Header fields sit at the top, the sync word at the bottom, padding in between.
  assign sync_frame = {SYNC_HDR, 16'(frames_cnt), 16'h0000, leds, lost_frames, total_frames,
                       {(FRAME_W-96){1'b0}}}
                    | {{(FRAME_W-32){1'b0}}, SYNC_WORD};

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    shift_d    = shift_q;
    frame_next = 1'b0;
    load_sync  = 1'b0;
    data_valid = (state_q == SEND);
    data_val   = data_valid ? shift_q[FRAME_W-1 -: OUT_W] : '0;

    case (state_q)
      IDLE: begin
        if (sync_cnt_q == '0) begin
          shift_d   = sync_frame;
          load_sync = 1'b1;
          beats_d   = BEATS_W'(BEATS);
          state_d   = SEND;
        end else if (frame_ready) begin
          shift_d    = frame;
          frame_next = 1'b1;
          beats_d    = BEATS_W'(BEATS);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (data_ready) begin
          shift_d = shift_q << OUT_W;
          beats_d = beats_q - BEATS_W'(1);
          if (beats_q == BEATS_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A forced sync beats a simultaneous reload so the request is never lost.
    if (force_sync) begin
      sync_cnt_d = '0;
    end else if (load_sync) begin
      sync_cnt_d = '1;
    end else if (sync_cnt_q != '0) begin
      sync_cnt_d = sync_cnt_q - SYNC_LOG2'(1);
    end else begin
      sync_cnt_d = sync_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beats_q    <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  // NOTE: the wide datapath register has no reset; data_val is gated by data_valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
